button_sync_reg: RTL and testbench



---
 rtl/button_sync_pkg.sv | 25 ++
 rtl/button_sync_reg_sync_chain.sv | 48 ++++
 rtl/button_sync_reg.sv | 129 ++++++++++++
 tb/tb_button_sync_reg.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/button_sync_pkg.sv
// ============================================================================
// button_sync_pkg
// ----------------------------------------------------------------------------
// Shared types and default parameter values for the push-button conditioning
// path (synchronizer -> optional debouncer -> one-shot pulse FSM).
//
// Contents:
//   state_t               2-bit FSM state encoding; code 3 is reserved and
//                         only reachable through an upset, never by design.
//   DEF_SYNC_STAGES       default depth of the input synchronizer (2..4)
//   DEF_DEBOUNCE_CYCLES   default debounce length; 0 bypasses the debouncer
// ============================================================================
package button_sync_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,   // waiting for a press
        S_PULSE = 2'd1,   // the single cycle in which Bo is high
        S_HELD  = 2'd2,   // press already reported, waiting for release
        S_RSVD  = 2'd3    // unused code, recovers to S_IDLE
    } state_t;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 0;

endpackage : button_sync_pkg

// File: rtl/button_sync_reg_sync_chain.sv
// ============================================================================
// sync_chain
// ----------------------------------------------------------------------------
// Generic multi-flop synchronizer for a single asynchronous level. The input
// is shifted through STAGES flops; q is the last flop of the chain, so q
// equals d delayed by STAGES rising edges of clk. All flops clear on srst.
// Intended for reuse on any other asynchronous board input.
//
// Parameters:
//   STAGES  number of flops in the chain (2..4 in practice, >=1 required)
//
// Ports:
//   clk   in  1  clock, all flops on posedge
//   srst  in  1  synchronous active-high reset, clears every stage
//   d     in  1  asynchronous input level
//   q     out 1  synchronized level (output of the last stage)
// ============================================================================
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic srst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Stage 0 captures the raw input; every later stage copies its predecessor.
    always_comb begin
        sync_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule : sync_chain

// File: rtl/button_sync_reg.sv
// ============================================================================
// button_sync_reg
// ----------------------------------------------------------------------------
// Converts an asynchronous push-button level into exactly one clock-wide
// pulse per press. Path:
//   Bis -> sync_chain (SYNC_STAGES flops) -> Bi_raw
//       -> debouncer (skipped when DEBOUNCE_CYCLES == 0) -> Bi
//       -> 3-state Moore FSM -> Bo
// A press held for any length yields one pulse; Bi must return to 0 before
// another pulse can be produced.
//
// Parameters:
//   SYNC_STAGES      synchronizer depth, legal range 2..4
//   DEBOUNCE_CYCLES  consecutive cycles Bi_raw must disagree with Bi before
//                    Bi follows it; 0 removes the debouncer entirely
//
// Ports (order kept for legacy positional hookups):
//   Clk  in  1  system clock, all logic on posedge
//   Bis  in  1  raw button level, asynchronous, 1 = pressed
//   Bo   out 1  one-cycle press pulse, straight from a flop
//   Rst  in  1  synchronous active-high reset, overrides everything
// ============================================================================
module button_sync_reg
    import button_sync_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic Clk,
    input  logic Bis,
    output logic Bo,
    input  logic Rst
);

    logic   bi_raw;   // synchronized button level
    logic   bi;       // filtered level seen by the FSM
    state_t state_q;
    state_t state_d;
    logic   bo_q;
    logic   bo_d;

    // ------------------------------------------------------------------------
    // Synchronizer
    // ------------------------------------------------------------------------
    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (Clk),
        .srst (Rst),
        .d    (Bis),
        .q    (bi_raw)
    );

    // ------------------------------------------------------------------------
    // Debouncer
    // ------------------------------------------------------------------------
    if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce

        assign bi = bi_raw;

    end else begin : g_debounce

        localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             bi_q;
        logic             bi_d;

        // cnt_q holds how many consecutive earlier cycles bi_raw already
        // disagreed with bi_q. The cycle that would make it DEBOUNCE_CYCLES
        // accepts the new level instead of counting; any agreeing cycle
        // (a bounce back) clears the count.
        always_comb begin
            cnt_d = '0;
            bi_d  = bi_q;
            if (bi_raw != bi_q) begin
                if (cnt_q == CNT_LAST) begin
                    bi_d = bi_raw;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge Clk) begin
            if (Rst) begin
                cnt_q <= '0;
                bi_q  <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                bi_q  <= bi_d;
            end
        end

        assign bi = bi_q;

    end

    // ------------------------------------------------------------------------
    // One-shot FSM
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = bi ? S_PULSE : S_IDLE;
            S_PULSE: state_d = bi ? S_HELD  : S_IDLE;
            S_HELD:  state_d = bi ? S_HELD  : S_IDLE;
            default: state_d = S_IDLE;   // reserved code, recover
        endcase
        // Bo is decoded from the next state and registered alongside it, so
        // it is high exactly while state_q is S_PULSE and never glitches.
        bo_d = (state_d == S_PULSE);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
            bo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            bo_q    <= bo_d;
        end
    end

    assign Bo = bo_q;

endmodule : button_sync_reg

// File: tb/tb_button_sync_reg.sv
// ============================================================================
// tb_button_sync_reg
// ----------------------------------------------------------------------------
// Drives one shared Bis/Rst stimulus into three configurations of
// button_sync_reg and compares every cycle against a behavioural model:
//   dut0  SYNC_STAGES=2 DEBOUNCE_CYCLES=0
//   dut1  SYNC_STAGES=2 DEBOUNCE_CYCLES=4
//   dut2  SYNC_STAGES=3 DEBOUNCE_CYCLES=2
// The model: Bi_raw is Bis seen SYNC_STAGES edges ago; Bi flips to Bi_raw
// once the last DEBOUNCE_CYCLES sampled Bi_raw values all differ from Bi;
// Bo is the rising edge of Bi, one cycle late.
// ============================================================================
module tb_button_sync_reg;

    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic rst;
    logic bis;
    logic bo0, bo1, bo2;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // model state
    bit hist   [NDUT][4];   // hist[m][k] = Bis sampled k+1 edges ago
    bit win    [NDUT][8];   // last sampled Bi_raw values, newest first
    bit m_bi   [NDUT];
    bit m_prev [NDUT];
    bit m_bo   [NDUT];

    // observed pulse bookkeeping for directed checks
    int pcnt   [NDUT];
    int pfirst [NDUT];

    always #10 clk = ~clk;

    button_sync_reg #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(0)) dut0 (
        .Clk(clk), .Bis(bis), .Bo(bo0), .Rst(rst));
    button_sync_reg #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut1 (
        .Clk(clk), .Bis(bis), .Bo(bo1), .Rst(rst));
    button_sync_reg #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(2)) dut2 (
        .Clk(clk), .Bis(bis), .Bo(bo2), .Rst(rst));

    function automatic int sync_of(input int m);
        case (m)
            0:       return 2;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int deb_of(input int m);
        case (m)
            0:       return 0;
            1:       return 4;
            default: return 2;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < NDUT; m++) begin
            for (int k = 0; k < 4; k++) hist[m][k] = 1'b0;
            for (int k = 0; k < 8; k++) win[m][k]  = 1'b0;
            m_bi[m]   = 1'b0;
            m_prev[m] = 1'b0;
            m_bo[m]   = 1'b0;
        end
    endtask

    // Advance the model by one rising edge with the given input levels.
    task automatic model_step(input bit b, input bit r);
        bit raw;
        bit seen;
        bit all_diff;
        int s;
        int n;
        if (r) begin
            model_reset();
            return;
        end
        for (int m = 0; m < NDUT; m++) begin
            s   = sync_of(m);
            n   = deb_of(m);
            raw = hist[m][s-1];
            for (int k = s - 1; k > 0; k--) hist[m][k] = hist[m][k-1];
            hist[m][0] = b;
            seen      = (n == 0) ? raw : m_bi[m];
            m_bo[m]   = seen && !m_prev[m];
            m_prev[m] = seen;
            if (n > 0) begin
                for (int k = n - 1; k > 0; k--) win[m][k] = win[m][k-1];
                win[m][0] = raw;
                all_diff = 1'b1;
                for (int k = 0; k < n; k++) begin
                    if (win[m][k] == m_bi[m]) all_diff = 1'b0;
                end
                if (all_diff) m_bi[m] = !m_bi[m];
            end
        end
    endtask

    task automatic clear_counts();
        for (int m = 0; m < NDUT; m++) begin
            pcnt[m]   = 0;
            pfirst[m] = -1;
        end
    endtask

    // One clock: drive at the falling edge, step model at the rising edge,
    // compare at the next falling edge.
    task automatic tick(input bit b, input bit r);
        logic obs [NDUT];
        bis = b;
        rst = r;
        @(posedge clk);
        model_step(b, r);
        cyc++;
        @(negedge clk);
        obs[0] = bo0;
        obs[1] = bo1;
        obs[2] = bo2;
        for (int m = 0; m < NDUT; m++) begin
            check_eq($sformatf("bo_dut%0d", m), {31'b0, obs[m]}, {31'b0, m_bo[m]});
            if (obs[m] === 1'b1) begin
                pcnt[m]++;
                if (pfirst[m] < 0) pfirst[m] = cyc;
            end
        end
        if (m_bo[0] || m_bo[1] || m_bo[2])
            $display("cycle %0d: bis=%0b rst=%0b expected bo=%0b%0b%0b observed bo=%0b%0b%0b",
                     cyc, b, r, m_bo[0], m_bo[1], m_bo[2], obs[0], obs[1], obs[2]);
    endtask

    task automatic ticks(input bit b, input int count);
        for (int i = 0; i < count; i++) tick(b, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int run;
        bit lvl;
        bis = 1'b0;
        rst = 1'b1;
        model_reset();
        clear_counts();
        @(negedge clk);

        // reset state
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
        ticks(1'b0, 4);

        // single press of 6 cycles
        clear_counts();
        start = cyc + 1;
        ticks(1'b1, 6);
        ticks(1'b0, 12);
        check_eq("single_cnt_d0", pcnt[0], 1);
        check_eq("single_lat_d0", pfirst[0] - start + 1, 3);
        check_eq("single_cnt_d1", pcnt[1], 1);
        check_eq("single_lat_d1", pfirst[1] - start + 1, 7);

        // long hold
        clear_counts();
        ticks(1'b1, 100);
        check_eq("hold_cnt_d0", pcnt[0], 1);
        check_eq("hold_cnt_d1", pcnt[1], 1);
        check_eq("hold_cnt_d2", pcnt[2], 1);
        ticks(1'b0, 10);

        // rapid 1-high/1-low presses x4
        clear_counts();
        start = cyc + 1;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0);
            tick(1'b0, 1'b0);
        end
        ticks(1'b0, 8);
        check_eq("rapid_cnt_d0", pcnt[0], 4);
        check_eq("rapid_lat_d0", pfirst[0] - start + 1, 3);
        check_eq("rapid_cnt_d1", pcnt[1], 0);
        check_eq("rapid_cnt_d2", pcnt[2], 0);

        // bounce 1-0-1-0 then steady press
        clear_counts();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        start = cyc + 1;
        ticks(1'b1, 14);
        check_eq("bounce_cnt_d1", pcnt[1], 1);
        check_eq("bounce_lat_d1", pfirst[1] - start + 1, 7);
        ticks(1'b0, 10);

        // reset during the Bo-high cycle with the button still held
        ticks(1'b1, 3);
        check_eq("pre_rst_bo_d0", {31'b0, bo0}, 32'd1);
        tick(1'b1, 1'b1);
        check_eq("rst_kill_bo_d0", {31'b0, bo0}, 32'd0);
        clear_counts();
        start = cyc + 1;
        ticks(1'b1, 12);
        check_eq("post_rst_cnt_d0", pcnt[0], 1);
        check_eq("post_rst_lat_d0", pfirst[0] - start + 1, 3);
        check_eq("post_rst_cnt_d1", pcnt[1], 1);
        ticks(1'b0, 10);

        // random runs with occasional resets
        for (int i = 0; i < 300; i++) begin
            lvl = 1'($urandom_range(0, 1));
            run = $urandom_range(1, 9);
            for (int k = 0; k < run; k++) begin
                tick(lvl, ($urandom_range(0, 99) == 0));
            end
        end
        ticks(1'b0, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule : tb_button_sync_reg
